// File: rtl/vip_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vip_uart_pkg
//  Description : Shared types and constants for the multi-channel UART RX VIP.
//  Revision    : 1.0 - initial release
// ============================================================================
package vip_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;

    localparam int MIN_SCALER = 4;

    // Mode 3 is an alias for "no parity"; only 1 and 2 carry a parity bit.
    function automatic logic parity_en(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vip_uart_rx_chan.sv
`default_nettype none
// ============================================================================
//  Module      : vip_uart_rx_chan
//  Description : One UART RX channel: input synchroniser, receive FSM and
//                character FIFO. Optional console logging when the macro
//                VIP_UART_RX_LOG_EN is defined (simulation only).
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_uart_rx_chan
    import vip_uart_pkg::*;
#(
`ifdef VIP_UART_RX_LOG_EN
    parameter int CH_ID      = 0,
`endif
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SCALER_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_rx,
    input  logic [SCALER_W-1:0]  i_scaler,
    input  logic [1:0]           i_parity,
    input  logic                 i_stop2,
    input  logic                 i_pop,
    input  logic                 i_clr_ovf,
    output logic [DATA_BITS-1:0] o_head_data,
    output logic [1:0]           o_head_err,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam int BW = 4;
    localparam logic [SCALER_W-1:0] MIN_SC = SCALER_W'(MIN_SCALER);

    logic [1:0]           sync_q;
    logic                 rx_prev_q;
    rx_state_t            state_q,    state_d;
    logic [SCALER_W-1:0]  cnt_q,      cnt_d;
    logic [BW-1:0]        bit_q,      bit_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [1:0]           err_q,      err_d;
    logic [SCALER_W-1:0]  scaler_q,   scaler_d;
    logic [1:0]           parity_q,   parity_d;
    logic                 stop2_q,    stop2_d;
    logic [AW:0]          wr_ptr_q,   wr_ptr_d;
    logic [AW:0]          rd_ptr_q,   rd_ptr_d;
    logic                 ovf_q,      ovf_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];

    logic                 rx_s;
    logic [SCALER_W-1:0]  eff_scaler;
    logic                 push;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 empty;
    logic                 full;
    logic [EW-1:0]        push_entry;

    // Receive FSM next-state: every sample is taken when the bit counter hits 0.
    always_comb begin
        rx_s       = sync_q[1];
        eff_scaler = (i_scaler < MIN_SC) ? MIN_SC : i_scaler;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        err_d      = err_q;
        scaler_d   = scaler_q;
        parity_d   = parity_q;
        stop2_d    = stop2_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    // Half a bit period puts the start-bit sample at mid-bit.
                    state_d    = START;
                    cnt_d      = eff_scaler >> 1;
                    scaler_d   = eff_scaler;
                    parity_d   = i_parity;
                    stop2_d    = i_stop2;
                    err_d      = 2'b00;
                    bit_d      = '0;
                    stop_idx_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = scaler_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    cnt_d   = scaler_q - 1'b1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        state_d = parity_en(parity_q) ? PARITY : STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == '0) begin
                    err_d[ERR_PARITY] = (^shift_q) ^ rx_s ^ (parity_q == PARITY_ODD);
                    state_d           = STOP;
                    cnt_d             = scaler_q - 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        err_d[ERR_FRAME] = 1'b1;
                    end
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        cnt_d      = scaler_q - 1'b1;
                    end else begin
                        // No wait for idle-high, so the next start edge is caught.
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        push_entry = {err_d, shift_q};
    end

    // FIFO control: a push into a full FIFO still lands if a pop frees the slot.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok   = i_pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
        if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end else if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers, synchroniser and FIFO pointers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            err_q      <= 2'b00;
            scaler_q   <= MIN_SC;
            parity_q   <= PARITY_NONE;
            stop2_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], i_rx};
            rx_prev_q  <= sync_q[1];
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            err_q      <= err_d;
            scaler_q   <= scaler_d;
            parity_q   <= parity_d;
            stop2_q    <= stop2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    // Character storage; contents are only observed through valid pointers.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    assign o_head_data = mem_q[rd_ptr_q[AW-1:0]][DATA_BITS-1:0];
    assign o_head_err  = mem_q[rd_ptr_q[AW-1:0]][EW-1:DATA_BITS];
    assign o_empty     = empty;
    assign o_full      = full;
    assign o_ovf       = ovf_q;

`ifdef VIP_UART_RX_LOG_EN
    string line_s;
    int    line_len;

    // Console line accumulation and error reporting.
    always @(posedge i_clk) begin
        if (push && push_entry[DATA_BITS+ERR_PARITY]) begin
            $warning("uart%0d: parity error at %0t", CH_ID, $time);
        end
        if (push && push_entry[DATA_BITS+ERR_FRAME]) begin
            $warning("uart%0d: framing error at %0t", CH_ID, $time);
        end
        if (push_ok) begin
            if (push_entry[DATA_BITS-1:0] == DATA_BITS'(8'h0A)) begin
                $display("uart%0d: %s", CH_ID, line_s);
                line_s   = "";
                line_len = 0;
            end else begin
                line_s   = $sformatf("%s%c", line_s, push_entry[DATA_BITS-1:0]);
                line_len = line_len + 1;
                if (line_len == 256) begin
                    $display("uart%0d: %s", CH_ID, line_s);
                    line_s   = "";
                    line_len = 0;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/vip_uart_rx_mc.sv
`default_nettype none
// ============================================================================
//  Module      : vip_uart_rx_mc
//  Description : Multi-channel UART receiver VIP. One receive channel per RX
//                line plus a shared polled read port with a registered output.
//                Define VIP_UART_RX_LOG_EN for per-channel console logging.
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_uart_rx_mc
    import vip_uart_pkg::*;
#(
    parameter  int CH_NUM     = 2,
    parameter  int DATA_BITS  = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int SCALER_W   = 16,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [CH_NUM-1:0]    i_rx,
    input  logic [SCALER_W-1:0]  i_scaler,
    input  logic [1:0]           i_parity,
    input  logic                 i_stop2,
    input  logic [CH_W-1:0]      i_rd_ch,
    input  logic                 i_rd_req,
    output logic                 o_rd_valid,
    output logic [DATA_BITS-1:0] o_rd_data,
    output logic [1:0]           o_rd_err,
    output logic [CH_NUM-1:0]    o_empty,
    output logic [CH_NUM-1:0]    o_full,
    output logic [CH_NUM-1:0]    o_ovf,
    input  logic [CH_NUM-1:0]    i_clr_ovf
);

    logic [DATA_BITS-1:0] head_data [CH_NUM];
    logic [1:0]           head_err  [CH_NUM];
    logic [CH_NUM-1:0]    empty_vec;
    logic [CH_NUM-1:0]    pop_vec;
    logic [DATA_BITS-1:0] sel_data;
    logic [1:0]           sel_err;
    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_BITS-1:0] rd_data_q,  rd_data_d;
    logic [1:0]           rd_err_q,   rd_err_d;

    generate
        for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
            vip_uart_rx_chan #(
`ifdef VIP_UART_RX_LOG_EN
                .CH_ID      (g),
`endif
                .DATA_BITS  (DATA_BITS),
                .FIFO_DEPTH (FIFO_DEPTH),
                .SCALER_W   (SCALER_W)
            ) u_chan (
                .i_clk       (i_clk),
                .i_nrst      (i_nrst),
                .i_rx        (i_rx[g]),
                .i_scaler    (i_scaler),
                .i_parity    (i_parity),
                .i_stop2     (i_stop2),
                .i_pop       (pop_vec[g]),
                .i_clr_ovf   (i_clr_ovf[g]),
                .o_head_data (head_data[g]),
                .o_head_err  (head_err[g]),
                .o_empty     (empty_vec[g]),
                .o_full      (o_full[g]),
                .o_ovf       (o_ovf[g])
            );
        end
    endgenerate

    // Read mux: an out-of-range channel matches no entry and is ignored.
    always_comb begin
        pop_vec  = '0;
        sel_data = '0;
        sel_err  = 2'b00;
        for (int i = 0; i < CH_NUM; i++) begin
            if (i_rd_ch == CH_W'(i)) begin
                pop_vec[i] = i_rd_req && !empty_vec[i];
                sel_data   = head_data[i];
                sel_err    = head_err[i];
            end
        end
        rd_valid_d = |pop_vec;
        rd_data_d  = rd_valid_d ? sel_data : rd_data_q;
        rd_err_d   = rd_valid_d ? sel_err  : rd_err_q;
    end

    // Read output register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 2'b00;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_data_q;
    assign o_rd_err   = rd_err_q;
    assign o_empty    = empty_vec;

endmodule
`default_nettype wire

// File: tb/tb_vip_uart_rx_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vip_uart_rx_mc
//  Description : Self-checking bench for vip_uart_rx_mc (2 channels, 8 bits,
//                16-deep FIFOs) using a per-channel expected-entry queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_uart_rx_mc;

    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  rx;
    logic [15:0] scaler;
    logic [1:0]  parity;
    logic        stop2;
    logic        rd_ch;
    logic        rd_req;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [1:0]  rd_err;
    logic [1:0]  empty;
    logic [1:0]  full;
    logic [1:0]  ovf;
    logic [1:0]  clr_ovf;

    int total = 0;
    int bad   = 0;
    logic [9:0] sb0 [$];
    logic [9:0] sb1 [$];

    always #5 clk = ~clk;

    vip_uart_rx_mc #(
        .CH_NUM     (2),
        .DATA_BITS  (8),
        .FIFO_DEPTH (16),
        .SCALER_W   (16)
    ) dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_rx       (rx),
        .i_scaler   (scaler),
        .i_parity   (parity),
        .i_stop2    (stop2),
        .i_rd_ch    (rd_ch),
        .i_rd_req   (rd_req),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_rd_err   (rd_err),
        .o_empty    (empty),
        .o_full     (full),
        .o_ovf      (ovf),
        .i_clr_ovf  (clr_ovf)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serial driver; caller is aligned 1 time unit after a rising edge.
    task automatic send_char(input int ch, input logic [7:0] data, input bit flip_par,
                             input bit bad_stop_last, input bit expect_push);
        int         s;
        int         nstop;
        logic       pbit;
        logic [1:0] err;
        s     = int'(scaler);
        pbit  = (parity == 2'd2) ? ~(^data) : ^data;
        err   = 2'b00;
        if (flip_par) pbit = ~pbit;
        if (flip_par && (parity == 2'd1 || parity == 2'd2)) err[0] = 1'b1;
        if (bad_stop_last) err[1] = 1'b1;
        rx[ch] = 1'b0;
        cycles(s);
        for (int i = 0; i < 8; i++) begin
            rx[ch] = data[i];
            cycles(s);
        end
        if (parity == 2'd1 || parity == 2'd2) begin
            rx[ch] = pbit;
            cycles(s);
        end
        nstop = stop2 ? 2 : 1;
        for (int k = 0; k < nstop; k++) begin
            rx[ch] = !(bad_stop_last && (k == nstop - 1));
            cycles(s);
        end
        rx[ch] = 1'b1;
        if (expect_push) begin
            if (ch == 0) sb0.push_back({err, data});
            else         sb1.push_back({err, data});
        end
    endtask

    task automatic rd_check(input int ch, input string name);
        logic [9:0] exp;
        rd_ch  = ch[0];
        rd_req = 1'b1;
        cycles(1);
        rd_req = 1'b0;
        total++;
        if (rd_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s valid: got %b want 1", name, rd_valid);
        end
        total++;
        if ((ch == 0 && sb0.size() == 0) || (ch == 1 && sb1.size() == 0)) begin
            bad++;
            $display("FAIL %s: nothing expected on ch%0d, got err=%b data=%h", name, ch, rd_err, rd_data);
        end else begin
            exp = (ch == 0) ? sb0.pop_front() : sb1.pop_front();
            if ({rd_err, rd_data} !== exp) begin
                bad++;
                $display("FAIL %s entry: got err=%b data=%h want err=%b data=%h",
                         name, rd_err, rd_data, exp[9:8], exp[7:0]);
            end
        end
        cycles(1);
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s valid pulse: got %b one cycle later want 0", name, rd_valid);
        end
    endtask

    task automatic test_reset;
        nrst    = 1'b0;
        rx      = 2'b11;
        scaler  = 16'd8;
        parity  = 2'd0;
        stop2   = 1'b0;
        rd_ch   = 1'b0;
        rd_req  = 1'b0;
        clr_ovf = 2'b00;
        cycles(4);
        total++; if (empty    !== 2'b11) begin bad++; $display("FAIL reset empty: got %b want 11", empty); end
        total++; if (full     !== 2'b00) begin bad++; $display("FAIL reset full: got %b want 00", full); end
        total++; if (ovf      !== 2'b00) begin bad++; $display("FAIL reset ovf: got %b want 00", ovf); end
        total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset rd_valid: got %b want 0", rd_valid); end
        total++; if (rd_data  !== 8'h00) begin bad++; $display("FAIL reset rd_data: got %h want 00", rd_data); end
        total++; if (rd_err   !== 2'b00) begin bad++; $display("FAIL reset rd_err: got %b want 00", rd_err); end
        nrst = 1'b1;
        cycles(3);
        // Pop on an empty channel must not produce a valid.
        rd_ch  = 1'b1;
        rd_req = 1'b1;
        cycles(1);
        rd_req = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL empty pop: rd_valid got %b want 0", rd_valid); end
    endtask

    task automatic test_back_to_back;
        scaler = 16'd8;
        parity = 2'd0;
        stop2  = 1'b0;
        send_char(0, 8'h55, 1'b0, 1'b0, 1'b1);
        send_char(0, 8'hA3, 1'b0, 1'b0, 1'b1);
        cycles(16);
        rd_check(0, "b2b_first");
        rd_check(0, "b2b_second");
        total++; if (empty[0] !== 1'b1) begin bad++; $display("FAIL b2b drained: empty0 got %b want 1", empty[0]); end
    endtask

    task automatic test_parity;
        scaler = 16'd8;
        parity = 2'd1;
        send_char(1, 8'h07, 1'b1, 1'b0, 1'b1);
        cycles(16);
        rd_check(1, "even_bad_parity");
        parity = 2'd2;
        send_char(1, 8'h07, 1'b0, 1'b0, 1'b1);
        cycles(16);
        rd_check(1, "odd_good_parity");
        parity = 2'd1;
        send_char(1, 8'hB4, 1'b0, 1'b0, 1'b1);
        cycles(16);
        rd_check(1, "even_good_parity");
        parity = 2'd0;
    endtask

    task automatic test_stop2;
        scaler = 16'd8;
        stop2  = 1'b1;
        send_char(0, 8'h81, 1'b0, 1'b1, 1'b1);
        cycles(8);
        send_char(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        cycles(16);
        stop2 = 1'b0;
        rd_check(0, "stop2_frame_err");
        rd_check(0, "stop2_next_char");
    endtask

    task automatic test_false_start;
        scaler = 16'd16;
        rx[0]  = 1'b0;
        cycles(2);
        rx[0]  = 1'b1;
        cycles(40);
        total++; if (empty[0] !== 1'b1) begin bad++; $display("FAIL false_start: empty0 got %b want 1", empty[0]); end
        send_char(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        cycles(24);
        rd_check(0, "after_false_start");
    endtask

    task automatic test_overflow;
        int n;
        scaler = 16'd4;
        for (int i = 0; i < 17; i++) begin
            send_char(0, 8'h10 + 8'(i), 1'b0, 1'b0, (i < 16));
        end
        cycles(8);
        total++; if (full[0] !== 1'b1) begin bad++; $display("FAIL ovf full: got %b want 1", full[0]); end
        total++; if (ovf[0]  !== 1'b1) begin bad++; $display("FAIL ovf sticky: got %b want 1", ovf[0]); end
        clr_ovf = 2'b01;
        cycles(1);
        clr_ovf = 2'b00;
        total++; if (ovf[0] !== 1'b0) begin bad++; $display("FAIL ovf clear: got %b want 0", ovf[0]); end
        // Measure character-to-push latency on the idle channel 1.
        n = 0;
        fork
            send_char(1, 8'h99, 1'b0, 1'b0, 1'b1);
            begin
                for (int c = 1; c <= 200; c++) begin
                    cycles(1);
                    if (empty[1] === 1'b0) begin
                        n = c;
                        break;
                    end
                end
            end
        join
        total++;
        if (n == 0) begin
            bad++;
            $display("FAIL push latency: ch1 empty got %b after 200 cycles want 0", empty[1]);
            n = 1;
        end
        cycles(8);
        // Same timing on the full channel 0, popping in the push cycle.
        fork
            send_char(0, 8'hE7, 1'b0, 1'b0, 1'b1);
            begin
                logic [9:0] exp;
                if (n > 1) cycles(n - 1);
                rd_ch  = 1'b0;
                rd_req = 1'b1;
                cycles(1);
                rd_req = 1'b0;
                exp = sb0.pop_front();
                total++;
                if (rd_valid !== 1'b1 || {rd_err, rd_data} !== exp) begin
                    bad++;
                    $display("FAIL pop_push_full: got v=%b err=%b data=%h want v=1 err=%b data=%h",
                             rd_valid, rd_err, rd_data, exp[9:8], exp[7:0]);
                end
            end
        join
        cycles(8);
        total++; if (ovf[0]  !== 1'b0) begin bad++; $display("FAIL pop_push_full ovf: got %b want 0", ovf[0]); end
        total++; if (full[0] !== 1'b1) begin bad++; $display("FAIL pop_push_full full: got %b want 1", full[0]); end
        for (int i = 0; i < 16; i++) begin
            rd_check(0, $sformatf("drain0_%0d", i));
        end
        rd_check(1, "drain1");
        total++; if (empty !== 2'b11) begin bad++; $display("FAIL drained empty: got %b want 11", empty); end
    endtask

    task automatic test_reset_mid;
        scaler = 16'd8;
        parity = 2'd0;
        stop2  = 1'b0;
        rx[1]  = 1'b0;
        cycles(8);
        rx[1]  = 1'b1;
        cycles(8);
        rx[1]  = 1'b0;
        cycles(12);
        nrst   = 1'b0;
        rx[1]  = 1'b1;
        cycles(3);
        nrst   = 1'b1;
        cycles(100);
        total++; if (empty[1] !== 1'b1) begin bad++; $display("FAIL reset_mid: empty1 got %b want 1", empty[1]); end
        send_char(1, 8'hC6, 1'b0, 1'b0, 1'b1);
        cycles(16);
        rd_check(1, "after_reset_mid");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity();
        test_stop2();
        test_false_start();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
